// File: rtl/pipe_share_arb.sv
// Round-robin arbiter sharing one DEPTH-stage register pipeline between N_REQ
// requesters; each word carries its requester id. Supports stall, drain, flush.
module pipe_share_arb #(
    parameter int N_REQ = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ-1:0]               req,
    input  logic [N_REQ*DW-1:0]            req_data,
    output logic [N_REQ-1:0]               gnt,
    output logic                           out_valid,
    output logic [DW-1:0]                  out_data,
    output logic [$clog2(N_REQ)-1:0]       out_id,
    input  logic                           out_ready,
    input  logic                           drain_req,
    input  logic                           flush,
    output logic                           drain_done,
    output logic                           busy,
    output logic [$clog2(DEPTH+1)-1:0]     occupancy
);

    localparam int IDW = $clog2(N_REQ);
    localparam int OW  = $clog2(DEPTH + 1);
    localparam int unsigned NR = N_REQ;

    typedef enum logic [1:0] {IDLE, RUN, HOLD, DRAIN} state_t;

    state_t           state;
    logic [IDW-1:0]   ptr;
    logic [DEPTH-1:0] stg_valid;
    logic [DW-1:0]    stg_data [DEPTH];
    logic [IDW-1:0]   stg_id   [DEPTH];

    logic             stall;
    logic             advance;
    logic             grants_en;
    logic             any_gnt;
    logic [IDW-1:0]   gnt_idx;
    logic [DEPTH-1:0] valid_nxt;
    logic [OW-1:0]    occ_nxt;
    int unsigned      rr_idx;

    always_comb begin
        stall     = stg_valid[DEPTH-1] && !out_ready;
        advance   = !stall;
        grants_en = (state == IDLE) || (state == RUN);
        any_gnt   = 1'b0;
        gnt_idx   = '0;
        rr_idx    = 0;
        gnt       = '0;
        // First requesting index at or after ptr, wrapping modulo N_REQ
        if (advance && grants_en && !flush && !rst) begin
            for (int unsigned off = 0; off < NR; off++) begin
                rr_idx = (32'(ptr) + off) % NR;
                if (!any_gnt && req[rr_idx[IDW-1:0]]) begin
                    any_gnt = 1'b1;
                    gnt_idx = rr_idx[IDW-1:0];
                end
            end
        end
        if (any_gnt) gnt[gnt_idx] = 1'b1;

        valid_nxt = stg_valid;
        if (flush) begin
            valid_nxt = '0;
        end else if (advance) begin
            valid_nxt[0] = any_gnt;
            for (int unsigned i = 1; i < DEPTH; i++) valid_nxt[i] = stg_valid[i-1];
        end
        occ_nxt = '0;
        for (int unsigned i = 0; i < DEPTH; i++) occ_nxt = occ_nxt + OW'(valid_nxt[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_valid <= '0;
            occupancy <= '0;
            ptr       <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stg_data[i] <= '0;
                stg_id[i]   <= '0;
            end
        end else begin
            stg_valid <= valid_nxt;
            occupancy <= occ_nxt;
            if (advance) begin
                stg_data[0] <= req_data[32'(gnt_idx)*DW +: DW];
                stg_id[0]   <= gnt_idx;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    stg_data[i] <= stg_data[i-1];
                    stg_id[i]   <= stg_id[i-1];
                end
            end
            if (any_gnt) ptr <= (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            drain_done <= 1'b0;
        end else begin
            drain_done <= 1'b0;
            if (flush) begin
                state <= IDLE;
                if (state == DRAIN || drain_req) drain_done <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (drain_req)    state <= DRAIN;
                        else if (any_gnt) state <= RUN;
                    end
                    RUN: begin
                        if (drain_req)                           state <= DRAIN;
                        else if (stall)                          state <= HOLD;
                        else if (occ_nxt == '0 && req == '0)     state <= IDLE;
                    end
                    HOLD: begin
                        if (drain_req)   state <= DRAIN;
                        else if (!stall) state <= RUN;
                    end
                    DRAIN: begin
                        if (occ_nxt == '0) begin
                            drain_done <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy      = (state != IDLE);
    assign out_valid = stg_valid[DEPTH-1];
    assign out_data  = stg_data[DEPTH-1];
    assign out_id    = stg_id[DEPTH-1];

endmodule

// File: tb/tb_pipe_share_arb.sv
// Self-checking bench for pipe_share_arb: per-scenario tasks with a scoreboard
// of expected {data, id} words pushed at grant time and popped on acceptance.
module tb_pipe_share_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_id;
    logic        out_ready;
    logic        drain_req;
    logic        flush;
    logic        drain_done;
    logic        busy;
    logic [1:0]  occupancy;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] id;
    } word_t;

    word_t sb[$];
    word_t exp_w;
    int    n_checks = 0;
    int    n_fail   = 0;

    pipe_share_arb #(.N_REQ(4), .DW(8), .DEPTH(3)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
        .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
        .out_ready(out_ready), .drain_req(drain_req), .flush(flush),
        .drain_done(drain_done), .busy(busy), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Leaves the bench 1 time unit after a rising edge with rst just released: cycle 0.
    task automatic do_reset;
        rst = 1'b1; req = '0; req_data = '0; out_ready = 1'b1;
        drain_req = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 4'b1111; req_data = 32'h01020304; out_ready = 1'b1;
        drain_req = 1'b0; flush = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({gnt, out_valid, occupancy, busy, drain_done} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_state: gnt=%b out_valid=%b occ=%0d busy=%b drain_done=%b, required all 0",
                     gnt, out_valid, occupancy, busy, drain_done);
        end
        do_reset();
    endtask

    task automatic test_single;
        logic [3:0] eg;
        logic [1:0] eo;
        do_reset();
        req_data = 32'h00A50000; req = 4'b0100;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) req = '0;
            @(negedge clk);
            eg = (k == 0) ? 4'b0100 : 4'b0000;
            eo = (k >= 1 && k <= 3) ? 2'd1 : 2'd0;
            n_checks++;
            if (gnt !== eg) begin
                n_fail++; $display("FAIL single_gnt k=%0d: got %b, required %b", k, gnt, eg);
            end
            if (gnt[2]) sb.push_back('{data: 8'hA5, id: 2'd2});
            n_checks++;
            if (occupancy !== eo) begin
                n_fail++; $display("FAIL single_occ k=%0d: got %0d, required %0d", k, occupancy, eo);
            end
            n_checks++;
            if (out_valid !== (k == 3)) begin
                n_fail++; $display("FAIL single_valid k=%0d: got %b, required %b", k, out_valid, k == 3);
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL single_word: unexpected %h/%0d, required none", out_data, out_id);
                end else begin
                    exp_w = sb.pop_front();
                    if ({out_data, out_id} !== exp_w) begin
                        n_fail++; $display("FAIL single_word: got %h/%0d, required %h/%0d",
                                           out_data, out_id, exp_w.data, exp_w.id);
                    end
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fairness;
        logic [3:0] eg;
        int         gi;
        do_reset();
        req_data = 32'h13121110;
        for (int k = 0; k < 13; k++) begin
            req = (k < 8) ? 4'b1111 : 4'b0000;
            @(negedge clk);
            gi = k % 4;
            eg = (k < 8) ? (4'b0001 << gi) : 4'b0000;
            n_checks++;
            if (gnt !== eg) begin
                n_fail++; $display("FAIL rr_gnt k=%0d: got %b, required %b", k, gnt, eg);
            end
            if (k < 8) sb.push_back('{data: 8'h10 + 8'(gi), id: 2'(gi)});
            n_checks++;
            if (out_valid !== (k >= 3 && k <= 10)) begin
                n_fail++; $display("FAIL rr_valid k=%0d: got %b, required %b", k, out_valid, k >= 3 && k <= 10);
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL rr_word: unexpected %h/%0d, required none", out_data, out_id);
                end else begin
                    exp_w = sb.pop_front();
                    if ({out_data, out_id} !== exp_w) begin
                        n_fail++; $display("FAIL rr_word k=%0d: got %h/%0d, required %h/%0d",
                                           k, out_data, out_id, exp_w.data, exp_w.id);
                    end
                end
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL rr_lost: %0d words outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_backpressure;
        logic [3:0] eg;
        int         cnt = 0;
        do_reset();
        for (int k = 0; k < 18; k++) begin
            req = (k < 12) ? 4'b0001 : 4'b0000;
            req_data[7:0] = 8'h30 + 8'(cnt);
            out_ready = !(k == 5 || k == 6);
            @(negedge clk);
            eg = (k < 12 && !(k >= 5 && k <= 7)) ? 4'b0001 : 4'b0000;
            n_checks++;
            if (gnt !== eg) begin
                n_fail++; $display("FAIL bp_gnt k=%0d: got %b, required %b", k, gnt, eg);
            end
            if (eg[0]) begin
                sb.push_back('{data: 8'h30 + 8'(cnt), id: 2'd0});
                cnt++;
            end
            if (k == 5 || k == 6) begin
                n_checks++;
                if ({out_valid, out_data, out_id, busy} !== {1'b1, 8'h32, 2'd0, 1'b1}) begin
                    n_fail++; $display("FAIL bp_hold k=%0d: got v=%b %h/%0d busy=%b, required v=1 32/0 busy=1",
                                       k, out_valid, out_data, out_id, busy);
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL bp_word: unexpected %h/%0d, required none", out_data, out_id);
                end else begin
                    exp_w = sb.pop_front();
                    if ({out_data, out_id} !== exp_w) begin
                        n_fail++; $display("FAIL bp_word k=%0d: got %h/%0d, required %h/%0d",
                                           k, out_data, out_id, exp_w.data, exp_w.id);
                    end
                end
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        n_checks++;
        if (sb.size() != 0 || cnt != 9) begin
            n_fail++; $display("FAIL bp_lost: outstanding=%0d grants=%0d, required 0 and 9", sb.size(), cnt);
        end
    endtask

    task automatic test_drain;
        logic [3:0] eg;
        int         cnt = 0;
        int         pulses = 0;
        do_reset();
        for (int k = 0; k < 14; k++) begin
            req = (k < 8) ? 4'b0010 : 4'b0000;
            req_data[15:8] = 8'h50 + 8'(cnt);
            drain_req = (k == 4 || k == 6 || k == 10);
            @(negedge clk);
            eg = (k <= 4) ? 4'b0010 : 4'b0000;
            n_checks++;
            if (gnt !== eg) begin
                n_fail++; $display("FAIL drain_gnt k=%0d: got %b, required %b", k, gnt, eg);
            end
            if (eg[1]) begin
                sb.push_back('{data: 8'h50 + 8'(cnt), id: 2'd1});
                cnt++;
            end
            if (k < 10) begin
                n_checks++;
                if (drain_done !== (k == 8)) begin
                    n_fail++; $display("FAIL drain_done k=%0d: got %b, required %b", k, drain_done, k == 8);
                end
                n_checks++;
                if (busy !== (k >= 1 && k <= 7)) begin
                    n_fail++; $display("FAIL drain_busy k=%0d: got %b, required %b", k, busy, k >= 1 && k <= 7);
                end
            end else if (drain_done) begin
                pulses++;
            end
            if (k == 8) begin
                n_checks++;
                if (occupancy !== 2'd0 || sb.size() != 0) begin
                    n_fail++; $display("FAIL drain_empty: occ=%0d outstanding=%0d, required 0 and 0",
                                       occupancy, sb.size());
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL drain_word: unexpected %h/%0d, required none", out_data, out_id);
                end else begin
                    exp_w = sb.pop_front();
                    if ({out_data, out_id} !== exp_w) begin
                        n_fail++; $display("FAIL drain_word k=%0d: got %h/%0d, required %h/%0d",
                                           k, out_data, out_id, exp_w.data, exp_w.id);
                    end
                end
            end
            @(posedge clk); #1;
        end
        drain_req = 1'b0;
        n_checks++;
        if (pulses != 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL drain_empty_pulse: pulses=%0d busy=%b, required 1 and 0", pulses, busy);
        end
    endtask

    task automatic test_flush;
        logic [3:0] eg;
        int         gi;
        do_reset();
        req_data = 32'h63626160;
        for (int k = 0; k < 12; k++) begin
            req   = (k <= 7) ? 4'b1111 : 4'b0000;
            flush = (k == 6);
            @(negedge clk);
            gi = (k == 7) ? 2 : k % 4;
            eg = (k < 6 || k == 7) ? (4'b0001 << gi) : 4'b0000;
            n_checks++;
            if (gnt !== eg) begin
                n_fail++; $display("FAIL flush_gnt k=%0d: got %b, required %b", k, gnt, eg);
            end
            if (eg != 4'b0000) sb.push_back('{data: 8'h60 + 8'(gi), id: 2'(gi)});
            if (k == 6) begin
                n_checks++;
                if (occupancy !== 2'd3) begin
                    n_fail++; $display("FAIL flush_full: occ=%0d, required 3", occupancy);
                end
            end
            if (k == 7) begin
                n_checks++;
                if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
                    n_fail++; $display("FAIL flush_clear: occ=%0d out_valid=%b, required 0 and 0",
                                       occupancy, out_valid);
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL flush_word: unexpected %h/%0d, required none", out_data, out_id);
                end else begin
                    exp_w = sb.pop_front();
                    if ({out_data, out_id} !== exp_w) begin
                        n_fail++; $display("FAIL flush_word k=%0d: got %h/%0d, required %h/%0d",
                                           k, out_data, out_id, exp_w.data, exp_w.id);
                    end
                end
            end
            // Words granted in cycles 4 and 5 are discarded by the flush edge
            if (k == 6) sb.delete();
            @(posedge clk); #1;
        end
        flush = 1'b0;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL flush_lost: %0d words outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_async_reset;
        do_reset();
        req_data = 32'h73727170; req = 4'b1111;
        repeat (5) begin
            @(posedge clk); #1;
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, gnt, occupancy, drain_done} !== 8'b0) begin
            n_fail++; $display("FAIL async_rst: out_valid=%b gnt=%b occ=%0d drain_done=%b, required all 0",
                               out_valid, gnt, occupancy, drain_done);
        end
        rst = 1'b0;
        sb.delete();
        for (int k = 0; k < 6; k++) begin
            if (k > 0) req = '0;
            @(negedge clk);
            n_checks++;
            if (gnt !== ((k == 0) ? 4'b0001 : 4'b0000)) begin
                n_fail++; $display("FAIL async_first_gnt k=%0d: got %b, required %b",
                                   k, gnt, (k == 0) ? 4'b0001 : 4'b0000);
            end
            if (k == 0) sb.push_back('{data: 8'h70, id: 2'd0});
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL async_word: unexpected %h/%0d, required none", out_data, out_id);
                end else begin
                    exp_w = sb.pop_front();
                    if ({out_data, out_id} !== exp_w) begin
                        n_fail++; $display("FAIL async_word k=%0d: got %h/%0d, required %h/%0d",
                                           k, out_data, out_id, exp_w.data, exp_w.id);
                    end
                end
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL async_lost: %0d words outstanding, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_drain();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
